// File: rtl/hamming_secded_decoder.sv
// SECDED decoder for 16-bit Hamming(15,11)+overall-parity words stored as byte pairs.
// Reads NUM_MSG encoded words, corrects/flags errors and writes {flag, data} byte pairs back.
module hamming_secded_decoder #(
   parameter int NUM_MSG  = 15,
   parameter int SRC_BASE = 30,
   parameter int DST_BASE = 0,
   parameter int AW       = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          done,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd_en,
   input  logic [7:0]    mem_rdata,
   output logic          mem_wr_en,
   output logic [7:0]    mem_wdata,
   output logic [3:0]    err1_cnt,
   output logic [3:0]    err2_cnt
);

   localparam int IW = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
   localparam int DPOS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

   typedef enum logic [2:0] {
      IDLE, RD_LO, RD_HI, CAPT, DEC, WR_LO, WR_HI, DONE
   } state_t;

   state_t        state, state_next;
   logic [IW-1:0] idx, idx_next;
   logic [7:0]    word_lo, word_lo_next;
   logic [7:0]    word_hi, word_hi_next;
   logic [7:0]    res_lo, res_lo_next;
   logic [7:0]    res_hi, res_hi_next;
   logic [AW-1:0] addr_next;
   logic          rd_en_next, wr_en_next, done_next;
   logic [7:0]    wdata_next;
   logic [3:0]    err1_next, err2_next;

   logic [15:0]   word;
   logic [3:0]    syn;
   logic          par;
   logic [1:0]    flag;
   logic [10:0]   data;

   function automatic logic [15:0] syn_mask(input int b);
      logic [15:0] m;
      m = '0;
      for (int k = 1; k < 16; k++) m[k] = ((k >> b) & 1) == 1;
      return m;
   endfunction

   function automatic logic [AW-1:0] byte_addr(input int base, input logic [IW-1:0] i,
                                                input logic upper);
      int a;
      a = base + 2 * int'(i) + int'(upper);
      return a[AW-1:0];
   endfunction

   assign word = {word_hi, word_lo};
   assign par  = ^word;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_syn
         assign syn[gi] = ^(word & syn_mask(gi));
      end
      // A data bit is inverted only when the single-error syndrome points at it.
      for (gi = 0; gi < 11; gi++) begin : g_data
         assign data[gi] = word[DPOS[gi]] ^ (par && (syn == 4'(DPOS[gi])));
      end
   endgenerate

   always_comb begin
      flag = 2'b00;
      if (par)
         flag = 2'b01;
      else if (syn != 4'd0)
         flag = 2'b10;
   end

   always_comb begin
      state_next   = state;
      idx_next     = idx;
      word_lo_next = word_lo;
      word_hi_next = word_hi;
      res_lo_next  = res_lo;
      res_hi_next  = res_hi;
      addr_next    = mem_addr;
      wdata_next   = mem_wdata;
      rd_en_next   = 1'b0;
      wr_en_next   = 1'b0;
      done_next    = 1'b0;
      err1_next    = err1_cnt;
      err2_next    = err2_cnt;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_next = RD_LO;
               idx_next   = '0;
               err1_next  = 4'd0;
               err2_next  = 4'd0;
               addr_next  = byte_addr(SRC_BASE, '0, 1'b0);
               rd_en_next = 1'b1;
            end else begin
               done_next = (state == DONE);
            end
         end
         RD_LO: begin
            state_next = RD_HI;
            addr_next  = byte_addr(SRC_BASE, idx, 1'b1);
            rd_en_next = 1'b1;
         end
         RD_HI: begin
            state_next   = CAPT;
            word_lo_next = mem_rdata;
         end
         CAPT: begin
            state_next   = DEC;
            word_hi_next = mem_rdata;
         end
         DEC: begin
            state_next  = WR_LO;
            res_lo_next = data[7:0];
            res_hi_next = {flag, 3'b000, data[10:8]};
            if (flag == 2'b01 && err1_cnt != 4'hF) err1_next = err1_cnt + 4'd1;
            if (flag == 2'b10 && err2_cnt != 4'hF) err2_next = err2_cnt + 4'd1;
            addr_next   = byte_addr(DST_BASE, idx, 1'b0);
            wr_en_next  = 1'b1;
            wdata_next  = data[7:0];
         end
         WR_LO: begin
            state_next = WR_HI;
            addr_next  = byte_addr(DST_BASE, idx, 1'b1);
            wr_en_next = 1'b1;
            wdata_next = res_hi;
         end
         WR_HI: begin
            if (idx == IW'(NUM_MSG - 1)) begin
               state_next = DONE;
               done_next  = 1'b1;
            end else begin
               state_next = RD_LO;
               idx_next   = idx + 1'b1;
               addr_next  = byte_addr(SRC_BASE, idx + 1'b1, 1'b0);
               rd_en_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs are registered so they are valid for the whole cycle of the state they belong to.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         idx       <= '0;
         word_lo   <= '0;
         word_hi   <= '0;
         res_lo    <= '0;
         res_hi    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_rd_en <= 1'b0;
         mem_wr_en <= 1'b0;
         done      <= 1'b0;
         err1_cnt  <= 4'd0;
         err2_cnt  <= 4'd0;
      end else begin
         state     <= state_next;
         idx       <= idx_next;
         word_lo   <= word_lo_next;
         word_hi   <= word_hi_next;
         res_lo    <= res_lo_next;
         res_hi    <= res_hi_next;
         mem_addr  <= addr_next;
         mem_wdata <= wdata_next;
         mem_rd_en <= rd_en_next;
         mem_wr_en <= wr_en_next;
         done      <= done_next;
         err1_cnt  <= err1_next;
         err2_cnt  <= err2_next;
      end
   end

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Bench for hamming_secded_decoder: byte memory model, directed vector table,
// randomized encoder outputs with injected errors, mid-run reset and busy-start checks.
module tb_hamming_secded_decoder;

   localparam int NUM_MSG = 15;
   localparam int SRC     = 30;
   localparam int DST     = 0;

   logic       clk = 1'b0;
   logic       reset, start;
   logic       done, rd_en, wr_en;
   logic [7:0] addr, wdata, rdata;
   logic [3:0] e1, e2;

   always #5 clk = ~clk;

   hamming_secded_decoder #(.NUM_MSG(NUM_MSG), .SRC_BASE(SRC), .DST_BASE(DST), .AW(8)) dut (
      .clk(clk), .reset(reset), .start(start), .done(done),
      .mem_addr(addr), .mem_rd_en(rd_en), .mem_rdata(rdata),
      .mem_wr_en(wr_en), .mem_wdata(wdata), .err1_cnt(e1), .err2_cnt(e2)
   );

   logic [7:0] mem [256];
   logic       tb_we = 1'b0;
   logic [7:0] tb_wa = 8'd0, tb_wd = 8'd0;

   always @(posedge clk) begin
      if (tb_we) mem[tb_wa] <= tb_wd;
      else if (wr_en) mem[addr] <= wdata;
      if (rd_en) rdata <= mem[addr];
   end

   typedef struct {
      logic [15:0] word;
      logic [7:0]  lo;
      logic [7:0]  hi;
   } vec_t;

   int         checks = 0;
   int         failures = 0;
   int         dpos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
   logic [7:0] exp_lo [NUM_MSG];
   logic [7:0] exp_hi [NUM_MSG];
   int         exp_e1, exp_e2;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] encode(input logic [10:0] d);
      logic [15:0] w;
      logic        x;
      w = '0;
      for (int j = 0; j < 11; j++) w[dpos[j]] = d[j];
      for (int p = 1; p <= 8; p = p * 2) begin
         x = 1'b0;
         for (int k = 1; k < 16; k++) if ((k & p) != 0) x = x ^ w[k];
         w[p] = x;
      end
      w[0] = ^w[15:1];
      return w;
   endfunction

   function automatic logic [10:0] extract(input logic [15:0] w);
      logic [10:0] d;
      for (int j = 0; j < 11; j++) d[j] = w[dpos[j]];
      return d;
   endfunction

   // Caller is positioned at a negedge; each poke lands on the following posedge.
   task automatic poke(input int a, input logic [7:0] d);
      tb_wa = a[7:0];
      tb_wd = d;
      tb_we = 1'b1;
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   task automatic load_word(input int i, input logic [15:0] w);
      poke(SRC + 2 * i, w[7:0]);
      poke(SRC + 2 * i + 1, w[15:8]);
   endtask

   task automatic fill_dest(input logic [7:0] v);
      @(negedge clk);
      for (int a = DST; a < DST + 2 * NUM_MSG; a++) poke(a, v);
   endtask

   task automatic run_to_done(input int busy_start_at, output int cycles,
                              output int first_rd, output int first_wr);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cycles = 0;
      first_rd = -1;
      first_wr = -1;
      while (!done && cycles < 1000) begin
         if (rd_en && first_rd < 0) first_rd = cycles;
         if (wr_en && first_wr < 0) first_wr = cycles;
         check("strobe_overlap", int'(rd_en && wr_en), 0);
         if (cycles == busy_start_at) start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
         cycles++;
      end
      if (cycles >= 1000) check("done_timeout", cycles, 90);
   endtask

   task automatic check_results(input string tag, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         $display("%s msg %0d: lo=%02h hi=%02h expect lo=%02h hi=%02h", tag, i,
                  mem[DST + 2 * i], mem[DST + 2 * i + 1], exp_lo[i], exp_hi[i]);
         check({tag, "_lo"}, int'(mem[DST + 2 * i]), int'(exp_lo[i]));
         check({tag, "_hi"}, int'(mem[DST + 2 * i + 1]), int'(exp_hi[i]));
      end
   endtask

   initial begin
      vec_t        tbl [5];
      int          cycles, first_rd, first_wr, guard;
      logic [10:0] d, dd;
      logic [15:0] w;
      int          p1, p2, nflip;

      tbl[0] = '{16'h0000, 8'h00, 8'h00};
      tbl[1] = '{16'h000F, 8'h01, 8'h00};
      tbl[2] = '{16'h0007, 8'h01, 8'h40};
      tbl[3] = '{16'h0001, 8'h00, 8'h40};
      tbl[4] = '{16'h0003, 8'h00, 8'h80};

      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_done", int'(done), 0);
      check("rst_rd_en", int'(rd_en), 0);
      check("rst_wr_en", int'(wr_en), 0);
      check("rst_addr", int'(addr), 0);
      check("rst_wdata", int'(wdata), 0);
      check("rst_err1", int'(e1), 0);
      check("rst_err2", int'(e2), 0);
      @(negedge clk);
      reset = 1'b0;

      // All-zero words
      fill_dest(8'hEE);
      for (int i = 0; i < NUM_MSG; i++) begin
         load_word(i, 16'h0000);
         exp_lo[i] = 8'h00;
         exp_hi[i] = 8'h00;
      end
      run_to_done(-1, cycles, first_rd, first_wr);
      check("zero_done_latency", cycles, 90);
      check("zero_first_rd", first_rd, 0);
      check("zero_first_wr", first_wr, 4);
      check("zero_err1", int'(e1), 0);
      check("zero_err2", int'(e2), 0);
      check_results("zero", 0, NUM_MSG - 1);

      // Directed vectors, cycled across all messages
      exp_e1 = 0;
      exp_e2 = 0;
      @(negedge clk);
      for (int i = 0; i < NUM_MSG; i++) begin
         load_word(i, tbl[i % 5].word);
         exp_lo[i] = tbl[i % 5].lo;
         exp_hi[i] = tbl[i % 5].hi;
         if (tbl[i % 5].hi[7:6] == 2'b01) exp_e1++;
         if (tbl[i % 5].hi[7:6] == 2'b10) exp_e2++;
      end
      run_to_done(-1, cycles, first_rd, first_wr);
      check("tbl_done_latency", cycles, 90);
      check("tbl_err1", int'(e1), exp_e1);
      check("tbl_err2", int'(e2), exp_e2);
      check_results("tbl", 0, NUM_MSG - 1);
      repeat (3) @(posedge clk);
      #1;
      check("tbl_done_hold", int'(done), 1);
      check("tbl_err1_hold", int'(e1), exp_e1);

      // Random encoder outputs with 75% single / 25% double bit flips
      exp_e1 = 0;
      exp_e2 = 0;
      @(negedge clk);
      for (int i = 0; i < NUM_MSG; i++) begin
         d = 11'($urandom);
         w = encode(d);
         nflip = ($urandom_range(0, 3) < 3) ? 1 : 2;
         p1 = $urandom_range(0, 15);
         p2 = (p1 + $urandom_range(1, 15)) % 16;
         w[p1] = ~w[p1];
         if (nflip == 2) begin
            w[p2] = ~w[p2];
            dd = extract(w);
            exp_e2++;
         end else begin
            dd = d;
            exp_e1++;
         end
         load_word(i, w);
         exp_lo[i] = dd[7:0];
         exp_hi[i] = {nflip[1:0], 3'b000, dd[10:8]};
      end
      run_to_done(-1, cycles, first_rd, first_wr);
      check("rnd_done_latency", cycles, 90);
      check("rnd_err1", int'(e1), exp_e1);
      check("rnd_err2", int'(e2), exp_e2);
      check_results("rnd", 0, NUM_MSG - 1);

      // Reset during message 7 of a run over the same random words
      fill_dest(8'hEE);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      guard = 0;
      while (!(rd_en && addr == 8'(SRC + 14)) && guard < 200) begin
         @(posedge clk);
         #1 guard++;
      end
      check("rst_mid_reached", int'(guard < 200), 1);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_rd_en", int'(rd_en), 0);
      check("rst_mid_wr_en", int'(wr_en), 0);
      check("rst_mid_done", int'(done), 0);
      check("rst_mid_err1", int'(e1), 0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_results("partial", 0, 6);
      for (int a = DST + 14; a < DST + 2 * NUM_MSG; a++)
         check("no_write_after_reset", int'(mem[a]), 8'hEE);

      // Restart, with a second start pulse while busy that must be ignored
      run_to_done(20, cycles, first_rd, first_wr);
      check("busy_start_latency", cycles, 90);
      check("restart_err1", int'(e1), exp_e1);
      check("restart_err2", int'(e2), exp_e2);
      check_results("restart", 0, NUM_MSG - 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
